// File: rtl/life_engine_seq.sv
// Row-sequential Game of Life engine: loads N rows, computes one row per cycle into a shadow, commits all at once.
// Latency: N+1 cycles from an accepted step to the state_o update; gen_done_o pulses the cycle after that.
// Backpressure: load_ready_o is low while a generation is in flight; step/run/load are ignored then.
module life_engine_seq #(
    parameter int M       = 16,
    parameter int N       = 16,
    parameter bit WRAP    = 1'b1,
    parameter bit HALT_EN = 1'b1,
    parameter int GEN_W   = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_valid_i,
    input  logic [M-1:0]     load_row_i,
    output logic             load_ready_o,
    input  logic             step_i,
    input  logic             run_i,
    output logic             busy_o,
    output logic             gen_done_o,
    output logic [GEN_W-1:0] gen_count_o,
    output logic             still_o,
    output logic             extinct_o,
    output logic [N*M-1:0]   state_o
);

    localparam int            PW   = $clog2(N);
    localparam logic [PW-1:0] LAST = PW'(N - 1);

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, COMMIT} fsm_t;
    fsm_t cur_st, nxt_st;

    logic [N-1:0][M-1:0] grid, shadow;
    logic [PW-1:0]       ptr, ptr_up, ptr_dn;
    logic [M-1:0]        row_up, row_mid, row_dn, row_nxt;
    logic [M-1:0]        up_l, up_r, mid_l, mid_r, dn_l, dn_r;
    logic                load_acc, last_row, halted, start;
    logic                new_still, new_extinct, run_cont;

    assign load_ready_o = (cur_st == IDLE) || (cur_st == LOAD);
    assign busy_o       = (cur_st == COMPUTE) || (cur_st == COMMIT);
    assign load_acc     = load_valid_i && load_ready_o;
    assign last_row     = (ptr == LAST);
    assign state_o      = grid;

    // Once a run has halted, holding run_i does not restart it; a load or a step is needed.
    assign halted      = HALT_EN && (still_o || extinct_o);
    assign start       = step_i || (run_i && !halted);
    assign new_still   = (shadow == grid);
    assign new_extinct = (shadow == '0);
    assign run_cont    = run_i && !(HALT_EN && (new_still || new_extinct));

    assign ptr_up  = (ptr == '0) ? LAST : ptr - 1'b1;
    assign ptr_dn  = last_row ? '0 : ptr + 1'b1;
    assign row_mid = grid[ptr];
    assign row_up  = (!WRAP && ptr == '0) ? '0 : grid[ptr_up];
    assign row_dn  = (!WRAP && last_row) ? '0 : grid[ptr_dn];

    // Bit x of *_l holds column x-1, bit x of *_r holds column x+1.
    assign up_l  = {row_up[M-2:0], WRAP ? row_up[M-1] : 1'b0};
    assign up_r  = {WRAP ? row_up[0] : 1'b0, row_up[M-1:1]};
    assign mid_l = {row_mid[M-2:0], WRAP ? row_mid[M-1] : 1'b0};
    assign mid_r = {WRAP ? row_mid[0] : 1'b0, row_mid[M-1:1]};
    assign dn_l  = {row_dn[M-2:0], WRAP ? row_dn[M-1] : 1'b0};
    assign dn_r  = {WRAP ? row_dn[0] : 1'b0, row_dn[M-1:1]};

    for (genvar x = 0; x < M; x++) begin : g_cell
        logic [3:0] cnt;
        assign cnt = 4'(up_l[x])  + 4'(row_up[x]) + 4'(up_r[x]) +
                     4'(mid_l[x]) + 4'(mid_r[x]) +
                     4'(dn_l[x])  + 4'(row_dn[x]) + 4'(dn_r[x]);
        assign row_nxt[x] = (cnt == 4'd3) || (row_mid[x] && cnt == 4'd2);
    end

    always_comb begin
        nxt_st = cur_st;
        case (cur_st)
            IDLE: begin
                if (load_acc)   nxt_st = LOAD;
                else if (start) nxt_st = COMPUTE;
            end
            LOAD:    if (load_acc && last_row) nxt_st = IDLE;
            COMPUTE: if (last_row) nxt_st = COMMIT;
            COMMIT:  nxt_st = run_cont ? COMPUTE : IDLE;
            default: nxt_st = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cur_st      <= IDLE;
            ptr         <= '0;
            grid        <= '0;
            shadow      <= '0;
            gen_count_o <= '0;
            still_o     <= 1'b0;
            extinct_o   <= 1'b0;
            gen_done_o  <= 1'b0;
        end else begin
            cur_st     <= nxt_st;
            gen_done_o <= (cur_st == COMMIT);
            case (cur_st)
                IDLE, LOAD: begin
                    if (load_acc) begin
                        grid[ptr] <= load_row_i;
                        ptr       <= ptr_dn;
                        if (last_row) begin
                            gen_count_o <= '0;
                            still_o     <= 1'b0;
                            extinct_o   <= 1'b0;
                        end
                    end
                end
                COMPUTE: begin
                    shadow[ptr] <= row_nxt;
                    ptr         <= ptr_dn;
                end
                COMMIT: begin
                    grid        <= shadow;
                    gen_count_o <= gen_count_o + 1'b1;
                    still_o     <= new_still;
                    extinct_o   <= new_extinct;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_life_engine_seq.sv
// Drives a toroidal/halting engine and a dead-edge/free-running engine against a cell-level Life model.
module tb_life_engine_seq;

    localparam int M = 7;
    localparam int N = 6;
    localparam int W = N * M;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]          rst, step, run, lvld;
    logic [1:0][M-1:0]   lrow;
    wire  [1:0]          ready, busy, done, still, ext;
    wire  [1:0][W-1:0]   st;
    wire  [15:0]         gc0;
    wire  [2:0]          gc1;

    life_engine_seq #(.M(M), .N(N), .WRAP(1'b1), .HALT_EN(1'b1), .GEN_W(16)) u_dut_wrap (
        .clk_i(clk), .reset_i(rst[0]), .load_valid_i(lvld[0]), .load_row_i(lrow[0]),
        .load_ready_o(ready[0]), .step_i(step[0]), .run_i(run[0]), .busy_o(busy[0]),
        .gen_done_o(done[0]), .gen_count_o(gc0), .still_o(still[0]), .extinct_o(ext[0]),
        .state_o(st[0])
    );

    life_engine_seq #(.M(M), .N(N), .WRAP(1'b0), .HALT_EN(1'b0), .GEN_W(3)) u_dut_flat (
        .clk_i(clk), .reset_i(rst[1]), .load_valid_i(lvld[1]), .load_row_i(lrow[1]),
        .load_ready_o(ready[1]), .step_i(step[1]), .run_i(run[1]), .busy_o(busy[1]),
        .gen_done_o(done[1]), .gen_count_o(gc1), .still_o(still[1]), .extinct_o(ext[1]),
        .state_o(st[1])
    );

    logic [W-1:0] mg     [2];
    logic [15:0]  mgen   [2];
    logic         mstill [2];
    logic         mext   [2];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic bit wrap_of(input bit k); return !k; endfunction
    function automatic bit halt_of(input bit k); return !k; endfunction
    function automatic logic [15:0] gmask(input bit k); return k ? 16'h0007 : 16'hFFFF; endfunction
    function automatic logic [15:0] get_gc(input bit k); return k ? {13'b0, gc1} : gc0; endfunction

    function automatic logic [W-1:0] life_next(input logic [W-1:0] g, input bit wrap);
        logic [W-1:0] r;
        r = '0;
        for (int y = 0; y < N; y++) begin
            for (int x = 0; x < M; x++) begin
                int cnt;
                cnt = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        int yy, xx;
                        yy = y + dy;
                        xx = x + dx;
                        if (dy == 0 && dx == 0) continue;
                        if (wrap) begin
                            yy = (yy + N) % N;
                            xx = (xx + M) % M;
                        end else if (yy < 0 || yy >= N || xx < 0 || xx >= M) begin
                            continue;
                        end
                        cnt += int'(g[yy*M + xx]);
                    end
                end
                r[y*M + x] = (cnt == 3) || (g[y*M + x] && cnt == 2);
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input bit k, input string tag);
        chk($sformatf("u%0d_%s_state", k, tag),   64'(st[k]),     64'(mg[k]));
        chk($sformatf("u%0d_%s_gen", k, tag),     64'(get_gc(k)), 64'(mgen[k]));
        chk($sformatf("u%0d_%s_still", k, tag),   64'(still[k]),  64'(mstill[k]));
        chk($sformatf("u%0d_%s_extinct", k, tag), 64'(ext[k]),    64'(mext[k]));
    endtask

    task automatic commit_model(input bit k);
        logic [W-1:0] nw;
        nw        = life_next(mg[k], wrap_of(k));
        mstill[k] = (nw == mg[k]);
        mext[k]   = (nw == '0);
        mg[k]     = nw;
        mgen[k]   = (mgen[k] + 16'd1) & gmask(k);
    endtask

    task automatic clear_model(input bit k);
        mg[k] = '0; mgen[k] = '0; mstill[k] = 1'b0; mext[k] = 1'b0;
    endtask

    task automatic do_load(input bit k, input logic [W-1:0] g, input bit collide, input string tag);
        for (int y = 0; y < N; y++) begin
            lvld[k] = 1'b1;
            lrow[k] = g[y*M +: M];
            if (collide && y == 0) begin
                step[k] = 1'b1;
                run[k]  = 1'b1;
            end
            chk($sformatf("u%0d_%s_ready", k, tag), 64'(ready[k]), 64'd1);
            @(negedge clk);
            step[k] = 1'b0;
            run[k]  = 1'b0;
            if (collide && y == 0) chk($sformatf("u%0d_%s_collide_busy", k, tag), 64'(busy[k]), 64'd0);
            if (y < N - 1 && $urandom_range(2) == 0) begin
                lvld[k] = 1'b0;
                step[k] = 1'($urandom_range(1));
                @(negedge clk);
                step[k] = 1'b0;
            end
        end
        lvld[k] = 1'b0;
        mg[k] = g; mgen[k] = '0; mstill[k] = 1'b0; mext[k] = 1'b0;
        chk($sformatf("u%0d_%s_busy", k, tag), 64'(busy[k]), 64'd0);
        chk_model(k, tag);
    endtask

    task automatic do_step(input bit k, input bit poke, input string tag);
        step[k] = 1'b1;
        @(negedge clk);
        step[k] = 1'b0;
        for (int i = 0; i <= N; i++) begin
            chk($sformatf("u%0d_%s_busy%0d", k, tag, i), 64'(busy[k]), 64'd1);
            if (i == N) chk($sformatf("u%0d_%s_hold", k, tag), 64'(st[k]), 64'(mg[k]));
            if (poke && i == 2) begin
                step[k] = 1'b1;
                lvld[k] = 1'b1;
                lrow[k] = M'($urandom);
                chk($sformatf("u%0d_%s_busy_ready", k, tag), 64'(ready[k]), 64'd0);
            end else begin
                step[k] = 1'b0;
                lvld[k] = 1'b0;
            end
            @(negedge clk);
        end
        step[k] = 1'b0;
        lvld[k] = 1'b0;
        commit_model(k);
        chk($sformatf("u%0d_%s_done", k, tag), 64'(done[k]), 64'd1);
        chk($sformatf("u%0d_%s_idle", k, tag), 64'(busy[k]), 64'd0);
        chk_model(k, tag);
        @(negedge clk);
        chk($sformatf("u%0d_%s_done_once", k, tag), 64'(done[k] | busy[k]), 64'd0);
    endtask

    task automatic do_run(input bit k, input int gens, input string tag);
        int cnt;
        bit stop;
        run[k] = 1'b1;
        if (halt_of(k) && (mstill[k] || mext[k])) begin
            cnt = 0;
            repeat (N + 3) begin
                @(negedge clk);
                if (busy[k] || done[k]) cnt++;
            end
            run[k] = 1'b0;
            chk($sformatf("u%0d_%s_halted_idle", k, tag), 64'(cnt), 64'd0);
            return;
        end
        @(negedge clk);
        if (gens == 1) run[k] = 1'b0;
        stop = 1'b0;
        for (int g = 1; g <= gens && !stop; g++) begin
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
            end while (!done[k] && cnt < 3 * N);
            chk($sformatf("u%0d_%s_period%0d", k, tag, g), 64'(cnt), 64'(N + 1));
            commit_model(k);
            chk_model(k, tag);
            stop = halt_of(k) && (mstill[k] || mext[k]);
            chk($sformatf("u%0d_%s_busy%0d", k, tag, g), 64'(busy[k]), 64'(!stop && g < gens));
            if (g == gens - 1) run[k] = 1'b0;
        end
        run[k] = 1'b0;
        cnt = 0;
        repeat (N + 2) begin
            @(negedge clk);
            if (busy[k] || done[k]) cnt++;
        end
        chk($sformatf("u%0d_%s_tail_idle", k, tag), 64'(cnt), 64'd0);
    endtask

    task automatic rand_grid(output logic [W-1:0] g, input int sparse);
        for (int i = 0; i < W; i++) g[i] = ($urandom_range(sparse) == 0);
    endtask

    task automatic reset_mid_compute(input bit k);
        int pulses;
        step[k] = 1'b1;
        @(negedge clk);
        step[k] = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst[k] = 1'b1;
        #1;
        clear_model(k);
        chk_model(k, "reset_mid");
        chk($sformatf("u%0d_reset_busy", k), 64'(busy[k]), 64'd0);
        chk($sformatf("u%0d_reset_ready", k), 64'(ready[k]), 64'd1);
        chk($sformatf("u%0d_reset_done", k), 64'(done[k]), 64'd0);
        @(negedge clk);
        rst[k] = 1'b0;
        pulses = 0;
        repeat (N + 3) begin
            @(negedge clk);
            if (done[k] || busy[k]) pulses++;
        end
        chk($sformatf("u%0d_reset_no_done", k), 64'(pulses), 64'd0);
    endtask

    task automatic suite(input bit k);
        logic [W-1:0] g;
        logic [W-1:0] blink;
        blink = (W'(4) << M) | (W'(4) << (2 * M)) | (W'(4) << (3 * M));
        do_load(k, blink, 1'b1, "blinker_load");
        do_step(k, 1'b1, "blinker_step1");
        chk($sformatf("u%0d_blinker_horiz", k), 64'(st[k]), 64'(W'(7'h0E) << (2 * M)));
        do_step(k, 1'b0, "blinker_step2");
        chk($sformatf("u%0d_blinker_back", k), 64'(st[k]), 64'(blink));
        chk($sformatf("u%0d_blinker_still", k), 64'(still[k]), 64'd0);

        g = (W'(6) << M) | (W'(6) << (2 * M));
        do_load(k, g, 1'b0, "block_load");
        do_run(k, 4, "block_run");

        g = W'(1) | (W'(1) << (M - 1)) | (W'(1) << ((N - 1) * M));
        do_load(k, g, 1'b0, "corner_load");
        do_step(k, 1'b0, "corner_step");
        do_run(k, 3, "corner_run");

        repeat (5) begin
            rand_grid(g, 2);
            do_load(k, g, 1'($urandom_range(1)), "rand_load");
            repeat (3) begin
                if ($urandom_range(1) == 1) do_step(k, 1'($urandom_range(1)), "rand_step");
                else                        do_run(k, $urandom_range(1, 5), "rand_run");
            end
        end

        rand_grid(g, 1);
        do_load(k, g, 1'b0, "long_load");
        do_run(k, 10, "long_run");

        rand_grid(g, 1);
        do_load(k, g, 1'b0, "pre_reset_load");
        do_step(k, 1'b0, "pre_reset_step");
        reset_mid_compute(k);

        rand_grid(g, 2);
        do_load(k, g, 1'b0, "post_reset_load");
        do_step(k, 1'b0, "post_reset_step");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst  = 2'b11;
        step = '0;
        run  = '0;
        lvld = '0;
        lrow = '0;
        clear_model(1'b0);
        clear_model(1'b1);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk_model(1'(i), "reset");
            chk($sformatf("u%0d_reset_ready", i), 64'(ready[i]), 64'd1);
            chk($sformatf("u%0d_reset_busy", i), 64'(busy[i]), 64'd0);
            chk($sformatf("u%0d_reset_done", i), 64'(done[i]), 64'd0);
        end
        rst = 2'b00;
        @(negedge clk);
        suite(1'b0);
        suite(1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/life_engine_seq.md
# life_engine_seq

Row-sequential Conway's Game of Life engine for an M-column by N-row grid. Loads the initial pattern one row at a time, then computes each generation at one row per clock into a shadow buffer and commits the whole grid at once. Supports single-step and free-running modes, toroidal or dead-boundary edges, a generation counter and still-life/extinction detection. It sits between the pattern-load host logic and the display/readout path, which reads the flattened grid.

## Interface
- M, 16, grid columns (≥3)
- N, 16, grid rows (≥3)
- WRAP, 1, 1 = toroidal edges; 0 = cells outside the grid are dead
- HALT_EN, 1, 1 = run mode stops automatically on still life or extinction
- GEN_W, 16, generation counter width
- clk_i  in  1  single clock; all state is updated on the rising edge
- reset_i  in  1  asynchronous, active-high reset
- load_valid_i  in  1  a row is offered on load_row_i
- load_row_i  in  M  row data; bit x is column x
- load_ready_o  out  1  engine accepts a row this cycle
- step_i  in  1  compute one generation
- run_i  in  1  compute generations continuously while high
- busy_o  out  1  a generation is being computed
- gen_done_o  out  1  one-cycle pulse after each commit
- gen_count_o  out  GEN_W  generations since the last completed load
- still_o  out  1  last committed generation equals the previous one
- extinct_o  out  1  last committed grid is all zero
- state_o  out  N*M  row-major grid; row y = state_o[y*M +: M], bit x = column x

## Operation
- FSM states are IDLE, LOAD, COMPUTE and COMMIT. Reset forces IDLE, row pointer 0, and every output to 0 except load_ready_o, which is 1.
- load_ready_o is high in IDLE and LOAD. A row is accepted on any edge where load_valid_i and load_ready_o are both high.
  - The accepted row is written to grid row ptr, and ptr increments.
  - The first accepted row moves IDLE to LOAD.
  - Acceptance of row N-1 returns the FSM to IDLE, resets ptr to 0, clears gen_count_o, still_o and extinct_o.
- In LOAD, step_i and run_i are ignored.
- In IDLE with no load accepted, step_i or run_i high moves the FSM to COMPUTE with r=0. A load accepted in the same cycle wins; the step is dropped and is not queued.
- COMPUTE, one row r per cycle:
  - Read rows r-1, r and r+1 of the current grid (state_o is unchanged during COMPUTE).
  - For each cell, count live neighbours into a 4-bit sum (0..8).
  - next = (cnt==3) | (alive & cnt==2).
  - Write the result to shadow row r.
  - With WRAP=1, indices are taken mod M/N. With WRAP=0, out-of-range neighbours count as 0.
  - After r=N-1, go to COMMIT.
- COMMIT, one cycle:
  - state_o ← shadow.
  - gen_count_o increments and wraps modulo 2^GEN_W.
  - still_o ← (shadow == old grid); extinct_o ← (shadow == 0).
  - gen_done_o pulses on the following cycle.
- After COMMIT: if run_i is high, and HALT_EN=0 or the new grid is neither still nor extinct, go straight to COMPUTE with r=0. Otherwise go to IDLE.
- step_i, run_i and load_valid_i are ignored while busy_o is high. Dropping run_i mid-generation finishes that generation and then goes to IDLE.

## Timing
- Step sampled at edge E0. Rows 0..N-1 are written at E1..EN. state_o updates at E(N+1).
- busy_o is high from after E0 through the cycle ending at E(N+1).
- gen_done_o is high for exactly the cycle after E(N+1).
- Run-mode period is N+1 cycles per generation with no idle gap.
- Loading a grid takes N accepted rows; back-to-back valid gives one row per cycle.
- Asserting reset_i mid-LOAD or mid-COMPUTE immediately clears the grid, shadow, counters and flags. The partial generation is discarded and gen_done_o does not pulse.

## Test plan
- Blinker, M=N=5, WRAP=0: load rows {0,0x04,0x04,0x04,0}, pulse step → at cycle 6, rows = {0,0,0x0E,0,0}, gen_count_o=1, gen_done_o pulse; step again restores the original, still_o=0.
- Glider, M=N=8, WRAP=1, run_i held: after 4 gen_done_o pulses (36 cycles) the pattern is shifted by +1 row and +1 column, gen_count_o=4; keeping run_i high, it wraps across both edges and reappears intact after 32 generations.
- Corners, M=N=4: load cells (0,0),(3,0),(0,3). With WRAP=1, one step gives all four corners set; the next step sets still_o=1, and with HALT_EN=1 run mode returns to IDLE. With WRAP=0, one step gives an all-zero grid and extinct_o=1.
- 2×2 block, run_i=1, HALT_EN=1: exactly one gen_done_o pulse, then still_o=1, busy_o=0, gen_count_o=1; with HALT_EN=0 it keeps running, with gen_done_o every N+1 cycles.
- Collisions: step_i and load_valid_i together in IDLE → row accepted, no COMPUTE. step_i pulsed mid-COMPUTE → ignored, exactly one commit. load_valid_i while busy → load_ready_o=0 and the row is not written.
- Reset at COMPUTE row 3 of a 16×16 grid → state_o=0, gen_count_o=0, busy_o=0, load_ready_o=1 at once; no gen_done_o pulse.
